// File: rtl/reg_demux_1xn_if.sv
// Handshake bundle for reg_demux_1xn: one upstream port,
// N registered downstream channels and a drop counter.
interface reg_demux_1xn_if #(
  parameter int DW = 8,
  parameter int N  = 16
);
  localparam int SW = $clog2(N);

  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic            in_bcast;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [7:0]      err_cnt;

  modport master (
    output in_data,
    output in_sel,
    output in_bcast,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  err_cnt
  );

  modport slave (
    input  in_data,
    input  in_sel,
    input  in_bcast,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output err_cnt
  );
endinterface

// File: rtl/reg_demux_1xn.sv
// 1-to-N registered demux: unicast or broadcast into
// per-channel holding registers, drops out-of-range selects.
module reg_demux_1xn #(
  parameter int DW = 8,
  parameter int N  = 16
) (
  input logic           clk,
  input logic           rst_n,
  reg_demux_1xn_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int NP = 1 << SW;

  logic [N-1:0][DW-1:0] data_q;
  logic [N-1:0]         vld_q;
  logic [7:0]           err_q;

  logic [N-1:0]  free;
  logic [NP-1:0] free_ext;
  logic [N-1:0]  load;
  logic          in_range;
  logic          ready;
  logic          xfer;
  logic          drop;

  assign free     = ~vld_q | bus.out_ready;
  assign free_ext = NP'(free);
  assign in_range = (SW+1)'(bus.in_sel) < (SW+1)'(N);

  always_comb begin
    ready = 1'b1;
    unique case (1'b1)
      bus.in_bcast:
        ready = &free;
      (~bus.in_bcast & in_range):
        ready = free_ext[bus.in_sel];
      default:
        ready = 1'b1;
    endcase
  end

  assign xfer = bus.in_valid & ready;
  assign drop = xfer & ~bus.in_bcast & ~in_range;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = xfer & (bus.in_bcast |
                (in_range & (bus.in_sel == SW'(k))));
    end
  end

  // a load wins over a consume so a draining channel never bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          data_q[k] <= bus.in_data;
          vld_q[k]  <= 1'b1;
        end else if (bus.out_ready[k]) begin
          vld_q[k]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (drop && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_reg_demux_1xn.sv
// Bench for reg_demux_1xn: N=16 against a channel model
// and scoreboard, N=12 for out-of-range drops.
module tb_reg_demux_1xn;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_demux_1xn_if #(.DW(8), .N(16)) b16 ();
  reg_demux_1xn_if #(.DW(8), .N(12)) b12 ();

  reg_demux_1xn #(.DW(8), .N(16)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );
  reg_demux_1xn #(.DW(8), .N(12)) u12 (
    .clk(clk), .rst_n(rst_n), .bus(b12)
  );

  task automatic check(string name,
                       logic [255:0] act,
                       logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // channel model: one slot per channel plus a per-channel
  // queue of accepted words awaiting consumption
  bit         m_vld [16];
  logic [7:0] m_dat [16];
  int         m_err;
  logic [7:0] sbq [16][$];
  bit         m_r;

  function automatic bit m_free(int k);
    return !m_vld[k] || b16.out_ready[k];
  endfunction

  function automatic bit m_ready();
    bit all_free = 1'b1;
    for (int k = 0; k < 16; k++)
      if (!m_free(k)) all_free = 1'b0;
    if (b16.in_bcast) return all_free;
    if (int'(b16.in_sel) < 16) return m_free(int'(b16.in_sel));
    return 1'b1;
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = 8'h00;
    end
    m_err = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        m_vld[k] = 1'b0;
        m_dat[k] = 8'h00;
        sbq[k].delete();
      end
      m_err = 0;
    end else begin
      m_r = b16.in_valid && m_ready();
      for (int k = 0; k < 16; k++) begin
        if (m_r && (b16.in_bcast || int'(b16.in_sel) == k)) begin
          m_vld[k] = 1'b1;
          m_dat[k] = b16.in_data;
          sbq[k].push_back(b16.in_data);
        end else if (b16.out_ready[k]) begin
          m_vld[k] = 1'b0;
        end
      end
      if (m_r && !b16.in_bcast && int'(b16.in_sel) >= 16)
        m_err = (m_err < 255) ? m_err + 1 : 255;
    end
  end

  logic [15:0]  ev;
  logic [127:0] ed;

  always @(negedge clk) begin
    for (int k = 0; k < 16; k++) begin
      ev[k]        = m_vld[k];
      ed[k*8 +: 8] = m_dat[k];
    end
    check("in_ready", 256'(b16.in_ready), 256'(m_ready()));
    check("out_valid", 256'(b16.out_valid), 256'(ev));
    check("out_data", 256'(b16.out_data), 256'(ed));
    check("err_cnt", 256'(b16.err_cnt), 256'(m_err));
    for (int k = 0; k < 16; k++) begin
      if (b16.out_valid[k] && b16.out_ready[k]) begin
        if (sbq[k].size() == 0) begin
          check("sb_extra", 256'(k), 256'(999));
        end else begin
          check("sb_order", 256'(b16.out_data[k*8 +: 8]),
                256'(sbq[k].pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put16(logic [3:0] s, logic [7:0] d, bit bc);
    b16.in_sel   = s;
    b16.in_data  = d;
    b16.in_bcast = bc;
    b16.in_valid = 1'b1;
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int left;
    b16.in_data = '0; b16.in_sel = '0; b16.in_bcast = 1'b0;
    b16.in_valid = 1'b0; b16.out_ready = '0;
    b12.in_data = '0; b12.in_sel = '0; b12.in_bcast = 1'b0;
    b12.in_valid = 1'b0; b12.out_ready = '0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_ov", 256'(b16.out_valid), 256'(16'h0000));
    check("rst_od", 256'(b16.out_data), 256'(0));
    check("rst_err", 256'(b12.err_cnt), 256'(8'd0));
    check("rst_rdy", 256'(b16.in_ready), 256'(1'b1));
    b16.in_bcast = 1'b1;
    #1;
    check("rst_bc_rdy", 256'(b16.in_ready), 256'(1'b1));
    b16.in_bcast = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // unicast to channel 5, then blocked second word
    step(); put16(4'd5, 8'hA5, 1'b0);
    step(); put16(4'd5, 8'h5A, 1'b0);
    @(negedge clk);
    check("uc_ov", 256'(b16.out_valid), 256'(16'h0020));
    check("uc_d5", 256'(b16.out_data[47:40]), 256'(8'hA5));
    check("uc_blk", 256'(b16.in_ready), 256'(1'b0));
    step(); b16.in_valid = 1'b0; b16.out_ready = 16'h0020;
    step(); b16.out_ready = '0;

    // back-to-back through a draining channel
    step(); b16.out_ready = 16'h0020; put16(4'd5, 8'h01, 1'b0);
    @(negedge clk);
    check("b2b_rdy0", 256'(b16.in_ready), 256'(1'b1));
    step(); put16(4'd5, 8'h02, 1'b0);
    @(negedge clk);
    check("b2b_d1", 256'(b16.out_data[47:40]), 256'(8'h01));
    check("b2b_rdy1", 256'(b16.in_ready), 256'(1'b1));
    step(); put16(4'd5, 8'h03, 1'b0);
    @(negedge clk);
    check("b2b_d2", 256'(b16.out_data[47:40]), 256'(8'h02));
    check("b2b_v2", 256'(b16.out_valid[5]), 256'(1'b1));
    step(); b16.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_d3", 256'(b16.out_data[47:40]), 256'(8'h03));
    check("b2b_v3", 256'(b16.out_valid[5]), 256'(1'b1));
    step(); b16.out_ready = '0;

    // broadcast blocked by a stalled channel 3
    step(); put16(4'd3, 8'h77, 1'b0);
    step(); put16(4'd0, 8'h3C, 1'b1);
    @(negedge clk);
    check("bc_blk", 256'(b16.in_ready), 256'(1'b0));
    step();
    @(negedge clk);
    check("bc_hold", 256'(b16.out_valid), 256'(16'h0008));
    step(); b16.out_ready = 16'h0008;
    @(negedge clk);
    check("bc_rdy", 256'(b16.in_ready), 256'(1'b1));
    step(); b16.out_ready = '0; b16.in_valid = 1'b0;
    b16.in_bcast = 1'b0;
    @(negedge clk);
    check("bc_ov", 256'(b16.out_valid), 256'(16'hFFFF));
    check("bc_od", 256'(b16.out_data), 256'({16{8'h3C}}));
    step(); b16.out_ready = '1;
    step(); b16.out_ready = '0;

    // N=12: in-range unicast, then out-of-range saturation
    step();
    b12.in_sel = 4'd11; b12.in_data = 8'hBB; b12.in_valid = 1'b1;
    step(); b12.in_valid = 1'b0;
    @(negedge clk);
    check("n12_ov", 256'(b12.out_valid), 256'(12'h800));
    check("n12_d11", 256'(b12.out_data[95:88]), 256'(8'hBB));
    step(); b12.out_ready = 12'h800;
    step(); b12.out_ready = '0;
    b12.in_sel = 4'd13; b12.in_data = 8'hEE; b12.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("oor_rdy", 256'(b12.in_ready), 256'(1'b1));
      check("oor_ov", 256'(b12.out_valid), 256'(12'h000));
      check("oor_err", 256'(b12.err_cnt),
            256'((i > 255) ? 255 : i));
    end
    @(negedge clk);
    check("oor_sat", 256'(b12.err_cnt), 256'(8'd255));
    step(); b12.in_valid = 1'b0;

    // asynchronous reset mid-stream
    step(); put16(4'd0, 8'h11, 1'b0);
    step(); put16(4'd7, 8'h77, 1'b0);
    step(); b16.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_ov", 256'(b16.out_valid), 256'(16'h0081));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov", 256'(b16.out_valid), 256'(16'h0000));
    check("arst_od", 256'(b16.out_data), 256'(0));
    check("arst_err", 256'(b12.err_cnt), 256'(8'd0));
    check("arst_ov12", 256'(b12.out_valid), 256'(12'h000));
    @(posedge clk);
    #1 rst_n = 1'b1;
    put16(4'd2, 8'h42, 1'b0);
    step(); b16.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ov", 256'(b16.out_valid), 256'(16'h0004));
    check("post_rst_d2", 256'(b16.out_data[23:16]), 256'(8'h42));
    step(); b16.out_ready = '1;
    step(); b16.out_ready = '0;

    // random unicast/broadcast traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step();
      b16.in_valid  = 1'($urandom_range(0, 1));
      b16.in_bcast  = ($urandom_range(0, 7) == 0);
      b16.in_sel    = 4'($urandom_range(0, 15));
      b16.in_data   = 8'($urandom);
      b16.out_ready = 16'($urandom);
    end
    step(); b16.in_valid = 1'b0; b16.out_ready = '1;
    repeat (3) step();
    @(negedge clk);
    left = 0;
    for (int k = 0; k < 16; k++) left += sbq[k].size();
    check("sb_left", 256'(left), 256'(0));
    check("drain_ov", 256'(b16.out_valid), 256'(16'h0000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_demux_1xn.md
REG_DEMUX_1XN -- requirements
Module: reg_demux_1xn

Interface
REQ-001 Parameter DW, default 8: data width in bits.
REQ-002 Parameter N, default 16: output channel count, legal range 2..256.
REQ-003 Local parameter SW = clog2(N): select width in bits, derived from N and not overridable.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_data, input, DW: payload to route.
REQ-007 Port in_sel, input, SW: target channel index.
REQ-008 Port in_bcast, input, 1: when 1, route to all N channels; in_sel is ignored.
REQ-009 Port in_valid, input, 1: upstream offers a word.
REQ-010 Port in_ready, output, 1: block accepts the word this cycle.
REQ-011 Port out_data, output, N*DW: channel k occupies bits [k*DW +: DW].
REQ-012 Port out_valid, output, N: channel k holds a word.
REQ-013 Port out_ready, input, N: downstream k consumes its word.
REQ-014 Port err_cnt, output, 8: count of dropped out-of-range selects.

Function
REQ-015 Each channel SHALL have exactly one holding register (data + valid); there is no other storage.
REQ-016 Channel k is free when ~out_valid[k] | out_ready[k]; this is the draining-accept rule.
REQ-017 Unicast in range (in_bcast=0, in_sel<N): in_ready SHALL equal free[in_sel].
REQ-018 Broadcast (in_bcast=1): in_ready SHALL equal the AND of free[k] over all k.
REQ-019 Out of range (in_bcast=0, in_sel>=N, possible only when N is not a power of 2): in_ready SHALL be 1.
REQ-020 Transfer occurs on any edge where in_valid & in_ready are both 1.
REQ-021 Out-of-range transfer: the word SHALL be dropped, no out_valid changes, and err_cnt increments by 1, saturating at 255.
REQ-022 in_ready is combinational from in_sel, in_bcast and out_ready/out_valid; it SHALL NOT depend on in_valid.
REQ-023 Latency: a word accepted at edge t SHALL appear on out_data/out_valid of each target channel after edge t, i.e. one cycle.
REQ-024 Channel k handshake: out_valid[k] & out_ready[k] at an edge consumes the word.
REQ-025 After consumption, out_valid[k] SHALL clear unless the same edge loads a new word into channel k.
REQ-026 Simultaneous consume and load on channel k: the new word SHALL be loaded, and out_valid[k] stays 1 with no bubble.
REQ-027 While out_valid[k]=1 and out_ready[k]=0, out_data[k] SHALL hold stable.
REQ-028 Non-target channels SHALL be unaffected by a transfer.
REQ-029 Broadcast SHALL load all N channels on the same edge, or none.
REQ-030 out_ready[k] SHALL be ignored while out_valid[k]=0.
REQ-031 in_data, in_sel and in_bcast SHALL be ignored when in_valid=0.

Reset
REQ-032 rst_n=0 SHALL asynchronously force out_valid=0, out_data=0 and err_cnt=0.
REQ-033 During reset, in_ready SHALL follow REQ-017..019 with all channels free, and no transfer SHALL be recorded.
REQ-034 Reset mid-operation SHALL discard all held words; the first transfer is possible on the first edge after rst_n rises.

Verification
REQ-035 N=16, DW=8 unicast: in_sel=5, in_data=0xA5, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid=0x0020, channel-5 data 0xA5; second word to sel 5 sees in_ready=0.
REQ-036 Back-to-back same channel, out_ready[5]=1: words 0x01,0x02,0x03 on consecutive cycles -> in_ready stays 1, channel 5 shows 0x01,0x02,0x03 on consecutive cycles, out_valid[5] never drops between them.
REQ-037 Broadcast blocked: channel 3 full with out_ready[3]=0; in_bcast=1, data 0x3C -> in_ready=0, no channel changes; raise out_ready[3] -> transfer; next cycle out_valid=0xFFFF, all channels 0x3C.
REQ-038 N=12: in_sel=13 valid for 300 cycles -> in_ready=1 throughout, out_valid stays 0, err_cnt saturates at 255.
REQ-039 Reset mid-stream: channels 0 and 7 full; assert rst_n=0 between edges -> out_valid=0, out_data=0 and err_cnt=0 immediately, without waiting for an edge.
REQ-040 Random unicast/broadcast traffic with random out_ready against a per-channel scoreboard -> no loss, duplication or reordering per channel.
